serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_tx                                                       |
// | Brief    : Start/data/stop serial transmitter, LSB first, fixed divider.   |
// | Revision : 1.0                                                           |
// +----------------------------------------------------------------------------+
module serial_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_W       = 8
) (
   input  logic              c,
   input  logic              rn,
   input  logic [DATA_W-1:0] d,
   input  logic              v,
   output logic              rdy,
   output logic              so,
   output logic              busy
);

   localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int c_bit_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLKS_PER_BIT - 1);
   localparam logic [c_cnt_w-1:0] c_baud_one  = c_cnt_w'(1);
   localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(DATA_W - 1);
   localparam logic [c_bit_w-1:0] c_bit_one   = c_bit_w'(1);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_start = 2'd1;
   localparam logic [1:0] c_data  = 2'd2;
   localparam logic [1:0] c_stop  = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [c_cnt_w-1:0] r_baud;
   logic [c_cnt_w-1:0] w_baud_nxt;
   logic [c_bit_w-1:0] r_bit;
   logic [c_bit_w-1:0] w_bit_nxt;
   logic [DATA_W-1:0]  r_shift;
   logic [DATA_W-1:0]  w_shift_nxt;
   logic               r_so;
   logic               w_so_nxt;
   logic               r_rdy;
   logic               w_rdy_nxt;
   logic               r_busy;
   logic               w_busy_nxt;
   logic               w_baud_wrap;
   logic               w_bit_last;

   assign w_baud_wrap = (r_baud == c_baud_last);
   assign w_bit_last  = (r_bit == c_bit_last);

   always_ff @(posedge c) begin
      if (!rn) begin
         r_state <= c_idle;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_so    <= 1'b1;
         r_rdy   <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_so    <= w_so_nxt;
         r_rdy   <= w_rdy_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle:  if (v)                         w_state_nxt = c_start;
         c_start: if (w_baud_wrap)               w_state_nxt = c_data;
         c_data:  if (w_baud_wrap && w_bit_last) w_state_nxt = c_stop;
         c_stop:  if (w_baud_wrap)               w_state_nxt = c_idle;
         default:                                w_state_nxt = c_idle;
      endcase
   end

   // Shift register always presents the next bit to send at bit 0.
   always_comb begin
      w_so_nxt    = r_so;
      w_rdy_nxt   = r_rdy;
      w_busy_nxt  = r_busy;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_baud_nxt  = w_baud_wrap ? '0 : r_baud + c_baud_one;
      case (r_state)
         c_idle: begin
            w_baud_nxt = '0;
            w_so_nxt   = 1'b1;
            if (v) begin
               w_shift_nxt = d;
               w_bit_nxt   = '0;
               w_so_nxt    = 1'b0;
               w_rdy_nxt   = 1'b0;
               w_busy_nxt  = 1'b1;
            end
         end
         c_start: begin
            if (w_baud_wrap) begin
               w_so_nxt    = r_shift[0];
               w_shift_nxt = r_shift >> 1;
            end
         end
         c_data: begin
            if (w_baud_wrap) begin
               if (w_bit_last) begin
                  w_so_nxt = 1'b1;
               end else begin
                  w_so_nxt    = r_shift[0];
                  w_shift_nxt = r_shift >> 1;
                  w_bit_nxt   = r_bit + c_bit_one;
               end
            end
         end
         c_stop: begin
            if (w_baud_wrap) begin
               w_so_nxt   = 1'b1;
               w_rdy_nxt  = 1'b1;
               w_busy_nxt = 1'b0;
            end
         end
         default: begin
            w_baud_nxt = '0;
            w_so_nxt   = 1'b1;
            w_rdy_nxt  = 1'b1;
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   assign rdy  = r_rdy;
   assign so   = r_so;
   assign busy = r_busy;

endmodule
`default_nettype wire
